div_unit: RTL and testbench
===========================

DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 Parameter: DATA_WIDTH, default 32, operand/result width.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 in_valid  input  1  requester presents an operand pair.
REQ-005 in_ready  output  1  unit can accept an operand pair.
REQ-006 dividend  input  DATA_WIDTH  numerator (A).
REQ-007 divisor  input  DATA_WIDTH  denominator (B).
REQ-008 is_signed  input  1  1 = two's-complement divide, 0 = unsigned divide.
REQ-009 out_valid  output  1  result registers hold a valid result.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 quotient  output  DATA_WIDTH  registered quotient.
REQ-012 remainder  output  DATA_WIDTH  registered remainder.
REQ-013 div_by_zero  output  1  registered flag; divisor was zero.

Function
REQ-014 FSM states: IDLE, BUSY, DONE; in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-015 Input transfer = in_valid & in_ready at a rising edge; operands and is_signed are latched, then IDLE->BUSY, or IDLE->DONE when divisor == 0.
REQ-016 BUSY: restoring shift-subtract, one quotient bit per cycle, MSB first, exactly DATA_WIDTH iterations, counted by an iteration counter.
REQ-017 Latency: out_valid rises exactly DATA_WIDTH+1 cycles after the accepting edge (33 for default).
REQ-018 Each iteration: partial remainder width DATA_WIDTH+1; shift in next dividend magnitude bit; trial subtract divisor magnitude; if no borrow, keep difference and set quotient bit to 1, else restore and set quotient bit to 0.
REQ-019 Signed mode: divide magnitudes; quotient negated when operand signs differ; remainder takes the sign of the dividend; remainder is zero when exact.
REQ-020 Signed overflow (-2^(W-1) / -1): quotient = 0x80000000, remainder = 0, div_by_zero = 0; no separate flag.
REQ-021 Divide by zero (both modes): quotient = all ones, remainder = dividend, div_by_zero = 1; out_valid at the edge after acceptance (latency 1).
REQ-022 DONE: quotient, remainder and div_by_zero SHALL stay stable while out_valid=1 & out_ready=0.
REQ-023 Output transfer = out_valid & out_ready at a rising edge; DONE->IDLE; in_ready goes to 1 in the following cycle (no same-cycle accept-and-release).
REQ-024 Operand inputs SHALL be ignored outside IDLE; in_valid in BUSY/DONE has no effect.
REQ-025 div_by_zero SHALL be 0 for every non-zero divisor result.
REQ-026 Outputs SHALL be driven from registers only; no combinational path from inputs to outputs except none (in_ready, out_valid decoded from state register).

Reset
REQ-027 rst=1 SHALL immediately force state IDLE, counter 0, quotient 0, remainder 0, div_by_zero 0, out_valid 0, in_ready 1 after release.
REQ-028 rst asserted mid-BUSY or in DONE SHALL abandon the operation; no result is delivered after release.
REQ-029 in_ready SHALL be 0 while rst=1.

Structure
REQ-030 Shared package div_pkg SHALL hold the state enumeration (IDLE, BUSY, DONE), DATA_WIDTH default, and iteration-count width constant.
REQ-031 One sub-module div_step (combinational: shifted partial remainder, divisor magnitude -> next remainder, quotient bit) SHALL be instantiated once; all sequencing stays in div_unit.
REQ-032 Sign pre-negation and post-correction SHALL be done in the accept and DONE-entry cycles respectively, not in div_step.

Verification
REQ-033 Unsigned 100 / 7 -> quotient 14, remainder 2, div_by_zero 0, out_valid 33 cycles after accept.
REQ-034 Signed -7 / 2 (0xFFFFFFF9, 0x2) -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; unsigned same operands -> quotient 0x7FFFFFFC, remainder 1.
REQ-035 Divisor 0, dividend 0x12345678, either mode -> quotient 0xFFFFFFFF, remainder 0x12345678, div_by_zero 1, out_valid 1 cycle after accept.
REQ-036 Signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0; hold out_ready=0 for 10 cycles -> outputs stable, in_ready 0 throughout.
REQ-037 Assert rst at iteration 10 of 0xFFFFFFFF / 3 -> outputs zero, in_ready 1 after release, no out_valid; new op 9 / 3 -> quotient 3, remainder 0.
REQ-038 Back-to-back: out_ready held 1, in_valid held 1 with a new pair -> second accept occurs one cycle after first output transfer; results in order.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the iterative divider.
package div_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 32;

    // Counter width for a DATA_WIDTH-iteration divide (counts 0 .. DATA_WIDTH-1).
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

    localparam int unsigned DEF_CNT_WIDTH = cnt_width(DEF_DATA_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration: shift in a dividend bit, trial subtract, restore on borrow.
module div_step
    import div_pkg::*;
#(
    parameter int unsigned W = DEF_DATA_WIDTH
) (
    input  logic [W:0]   rem_in,
    input  logic         in_bit,
    input  logic [W-1:0] dvs,
    output logic [W:0]   rem_out,
    output logic         quo_bit
);

    logic [W+1:0] shifted;
    logic [W+1:0] diff;

    // Partial remainder is always below the divisor, so the shifted value never overflows W+2 bits.
    always_comb begin
        shifted = {rem_in, in_bit};
        diff    = shifted - {2'b00, dvs};
        quo_bit = ~diff[W+1];
        rem_out = quo_bit ? diff[W:0] : shifted[W:0];
    end

endmodule

// File: rtl/div_unit.sv
// Iterative restoring divider, signed/unsigned, valid/ready on both sides.
module div_unit
    import div_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    input  logic                  is_signed,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic [DATA_WIDTH-1:0] remainder,
    output logic                  div_by_zero
);

    localparam int unsigned   W         = DATA_WIDTH;
    localparam int unsigned   CW        = cnt_width(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(DATA_WIDTH - 1);

    state_t        state;
    state_t        state_next;

    logic [CW-1:0] iter_cnt;
    logic [W:0]    part_rem;
    logic [W-1:0]  dvd_shift;
    logic [W-1:0]  dvs_mag;
    logic [W-2:0]  quo_shift;
    logic          neg_quo;
    logic          neg_rem;

    logic [W:0]    rem_next;
    logic          quo_bit;
    logic [W-1:0]  quo_next;
    logic [W-1:0]  rem_mag;

    logic          accept;
    logic          dvs_zero;
    logic          last_iter;
    logic          dvd_neg;
    logic          dvs_neg;

    // Handshake and operand decode.
    assign dvd_neg   = is_signed & dividend[W-1];
    assign dvs_neg   = is_signed & divisor[W-1];
    assign accept    = (state == IDLE) & in_valid;
    assign dvs_zero  = (divisor == '0);
    assign last_iter = (iter_cnt == LAST_ITER);
    assign quo_next  = {quo_shift, quo_bit};
    assign rem_mag   = rem_next[W-1:0];

    // Handshake outputs are pure decodes of the state register; reset masks in_ready.
    assign in_ready  = (state == IDLE) & ~rst;
    assign out_valid = (state == DONE);

    div_step #(
        .W (W)
    ) u_step (
        .rem_in  (part_rem),
        .in_bit  (dvd_shift[W-1]),
        .dvs     (dvs_mag),
        .rem_out (rem_next),
        .quo_bit (quo_bit)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; zero divisor skips the iteration phase entirely.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_next = dvs_zero ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (last_iter) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Working registers: magnitudes and sign flags captured at accept, shifted once per BUSY cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iter_cnt  <= '0;
            part_rem  <= '0;
            dvd_shift <= '0;
            dvs_mag   <= '0;
            quo_shift <= '0;
            neg_quo   <= 1'b0;
            neg_rem   <= 1'b0;
        end else if (accept) begin
            iter_cnt  <= '0;
            part_rem  <= '0;
            quo_shift <= '0;
            dvd_shift <= dvd_neg ? -dividend : dividend;
            dvs_mag   <= dvs_neg ? -divisor : divisor;
            neg_quo   <= dvd_neg ^ dvs_neg;
            neg_rem   <= dvd_neg;
        end else if (state == BUSY) begin
            iter_cnt  <= iter_cnt + CW'(1);
            part_rem  <= rem_next;
            dvd_shift <= {dvd_shift[W-2:0], 1'b0};
            quo_shift <= quo_next[W-2:0];
        end
    end

    // Result registers: loaded on DONE entry (sign-corrected) and held until the next result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept && dvs_zero) begin
            quotient    <= '1;
            remainder   <= dividend;
            div_by_zero <= 1'b1;
        end else if ((state == BUSY) && last_iter) begin
            quotient    <= neg_quo ? -quo_next : quo_next;
            remainder   <= neg_rem ? -rem_mag : rem_mag;
            div_by_zero <= 1'b0;
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: scoreboard of reference results, per-feature tasks.
module tb_div_unit;

    localparam int unsigned W = 32;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         is_signed;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           lat;
    } exp_t;

    exp_t sb_q[$];
    int   acc_q[$];
    int   xfer_q[$];
    int   cyc      = 0;
    int   checks   = 0;
    int   failures = 0;

    div_unit #(
        .DATA_WIDTH (W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .is_signed   (is_signed),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter plus a log of handshake edges.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (in_valid === 1'b1 && in_ready === 1'b1) acc_q.push_back(cyc);
        if (out_valid === 1'b1 && out_ready === 1'b1) xfer_q.push_back(cyc);
    end

    // Reference model: 64-bit arithmetic sidesteps the -2^31 / -1 overflow.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        exp_t   e;
        longint sa;
        longint sb;
        if (b == '0) begin
            e.q = '1; e.r = a; e.dbz = 1'b1; e.lat = 1;
        end else begin
            e.dbz = 1'b0;
            e.lat = int'(W) + 1;
            if (s) begin
                sa  = longint'($signed(a));
                sb  = longint'($signed(b));
                e.q = W'(sa / sb);
                e.r = W'(sa % sb);
            end else begin
                e.q = a / b;
                e.r = a % b;
            end
        end
        return e;
    endfunction

    // Present an operand pair, push its expected result, wait (bounded) for acceptance.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, output int acc);
        bit done;
        done = 1'b0;
        acc  = -1;
        @(negedge clk);
        dividend  = a;
        divisor   = b;
        is_signed = s;
        in_valid  = 1'b1;
        sb_q.push_back(model(a, b, s));
        for (int k = 0; k < 100 && !done; k++) begin
            if (in_ready === 1'b1) begin
                @(posedge clk);
                #1;
                acc  = cyc;
                done = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        in_valid = 1'b0;
        if (!done) begin
            void'(sb_q.pop_back());
            checks++;
            failures++;
            $display("FAIL accept_timeout a=%h b=%h", a, b);
        end
    endtask

    // Wait (bounded) for out_valid, sampled on the falling edge.
    task automatic wait_out(output bit found, output int seen);
        found = 1'b0;
        seen  = -1;
        for (int k = 0; k < 200 && !found; k++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                found = 1'b1;
                seen  = cyc;
            end
        end
    endtask

    // One-cycle out_ready pulse, then settle on the falling edge.
    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || quotient !== '0 || remainder !== '0 || div_by_zero !== 1'b0) begin
            failures++;
            $display("FAIL reset_state got in_ready=%b out_valid=%b q=%h r=%h dbz=%b want 0 0 0 0 0",
                     in_ready, out_valid, quotient, remainder, div_by_zero);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_unsigned();
        logic [W-1:0] ta[5] = '{32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'd0, 32'd5};
        logic [W-1:0] tb[5] = '{32'd7,   32'h2,         32'h1,         32'd5, 32'd9};
        int acc, seen; bit found; exp_t e;
        for (int i = 0; i < 5; i++) begin
            issue(ta[i], tb[i], 1'b0, acc);
            if (acc < 0) continue;
            wait_out(found, seen);
            checks++;
            if (!found) begin
                failures++;
                $display("FAIL unsigned_%0d no out_valid", i);
                void'(sb_q.pop_front());
                continue;
            end
            e = sb_q.pop_front();
            checks++;
            if (quotient !== e.q || remainder !== e.r || div_by_zero !== e.dbz) begin
                failures++;
                $display("FAIL unsigned_%0d got q=%h r=%h dbz=%b want q=%h r=%h dbz=%b",
                         i, quotient, remainder, div_by_zero, e.q, e.r, e.dbz);
            end
            checks++;
            if (seen - acc + 1 !== e.lat) begin
                failures++;
                $display("FAIL unsigned_%0d latency got %0d want %0d", i, seen - acc + 1, e.lat);
            end
            release_out();
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                failures++;
                $display("FAIL unsigned_%0d release got out_valid=%b in_ready=%b want 0 1", i, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_signed();
        logic [W-1:0] ta[5] = '{32'hFFFF_FFF9, 32'd7,         32'hFFFF_FFF9, 32'd6,         32'd5};
        logic [W-1:0] tb[5] = '{32'h2,         32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'hFFFF_FFFF};
        int acc, seen; bit found; exp_t e;
        for (int i = 0; i < 5; i++) begin
            issue(ta[i], tb[i], 1'b1, acc);
            if (acc < 0) continue;
            wait_out(found, seen);
            checks++;
            if (!found) begin
                failures++;
                $display("FAIL signed_%0d no out_valid", i);
                void'(sb_q.pop_front());
                continue;
            end
            e = sb_q.pop_front();
            checks++;
            if (quotient !== e.q || remainder !== e.r || div_by_zero !== e.dbz || seen - acc + 1 !== e.lat) begin
                failures++;
                $display("FAIL signed_%0d got q=%h r=%h dbz=%b lat=%0d want q=%h r=%h dbz=%b lat=%0d",
                         i, quotient, remainder, div_by_zero, seen - acc + 1, e.q, e.r, e.dbz, e.lat);
            end
            release_out();
        end
    endtask

    task automatic test_div_by_zero();
        int acc, seen; bit found; exp_t e;
        for (int m = 0; m < 2; m++) begin
            issue(32'h1234_5678, 32'h0, m[0], acc);
            if (acc < 0) continue;
            wait_out(found, seen);
            checks++;
            if (!found) begin
                failures++;
                $display("FAIL dbz_mode%0d no out_valid", m);
                void'(sb_q.pop_front());
                continue;
            end
            e = sb_q.pop_front();
            checks++;
            if (quotient !== e.q || remainder !== e.r || div_by_zero !== e.dbz) begin
                failures++;
                $display("FAIL dbz_mode%0d got q=%h r=%h dbz=%b want q=%h r=%h dbz=%b",
                         m, quotient, remainder, div_by_zero, e.q, e.r, e.dbz);
            end
            checks++;
            if (seen - acc + 1 !== e.lat) begin
                failures++;
                $display("FAIL dbz_mode%0d latency got %0d want %0d", m, seen - acc + 1, e.lat);
            end
            release_out();
        end
    endtask

    // Overflow case, then hold the result against back-pressure while junk requests are offered.
    task automatic test_overflow_hold();
        int acc, seen; bit found; exp_t e;
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, acc);
        if (acc < 0) return;
        wait_out(found, seen);
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL overflow no out_valid");
            void'(sb_q.pop_front());
            return;
        end
        e = sb_q.pop_front();
        checks++;
        if (quotient !== e.q || remainder !== e.r || div_by_zero !== e.dbz) begin
            failures++;
            $display("FAIL overflow got q=%h r=%h dbz=%b want q=%h r=%h dbz=%b",
                     quotient, remainder, div_by_zero, e.q, e.r, e.dbz);
        end
        dividend  = 32'hDEAD_BEEF;
        divisor   = 32'h0;
        is_signed = 1'b0;
        in_valid  = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== e.q || remainder !== e.r || div_by_zero !== e.dbz) begin
                failures++;
                $display("FAIL hold_%0d got v=%b rdy=%b q=%h r=%h dbz=%b want 1 0 q=%h r=%h dbz=%b",
                         k, out_valid, in_ready, quotient, remainder, div_by_zero, e.q, e.r, e.dbz);
            end
        end
        in_valid = 1'b0;
        release_out();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL hold_release got out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
        end
    endtask

    // Abandon an operation mid-iteration; nothing may come out, and the unit must work afterwards.
    task automatic test_reset_mid_busy();
        int acc, seen; bit found; bit leaked; exp_t e;
        issue(32'hFFFF_FFFF, 32'd3, 1'b0, acc);
        if (acc < 0) return;
        void'(sb_q.pop_back());
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || quotient !== '0 || remainder !== '0 || div_by_zero !== 1'b0) begin
            failures++;
            $display("FAIL midbusy_reset got rdy=%b v=%b q=%h r=%h dbz=%b want 0 0 0 0 0",
                     in_ready, out_valid, quotient, remainder, div_by_zero);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL midbusy_release in_ready got %b want 1", in_ready);
        end
        leaked = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) leaked = 1'b1;
        end
        checks++;
        if (leaked) begin
            failures++;
            $display("FAIL midbusy_leak out_valid seen after reset want never");
        end
        issue(32'd9, 32'd3, 1'b0, acc);
        if (acc < 0) return;
        wait_out(found, seen);
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL after_reset no out_valid");
            void'(sb_q.pop_front());
            return;
        end
        e = sb_q.pop_front();
        checks++;
        if (quotient !== e.q || remainder !== e.r || div_by_zero !== e.dbz) begin
            failures++;
            $display("FAIL after_reset got q=%h r=%h dbz=%b want q=%h r=%h dbz=%b",
                     quotient, remainder, div_by_zero, e.q, e.r, e.dbz);
        end
        release_out();
    endtask

    task automatic test_reset_in_done();
        int acc, seen; bit found;
        issue(32'd5, 32'd0, 1'b0, acc);
        if (acc < 0) return;
        void'(sb_q.pop_back());
        wait_out(found, seen);
        rst = 1'b1;
        #1;
        checks++;
        if (!found || out_valid !== 1'b0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL done_reset got found=%b out_valid=%b in_ready=%b want 1 0 0", found, out_valid, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL done_release got out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_random();
        int acc, seen; bit found; exp_t e;
        logic [W-1:0] a, b, t;
        logic s;
        for (int i = 0; i < 8; i++) begin
            a = $urandom;
            t = $urandom_range(1, 100);
            b = (i % 2 == 0) ? $urandom : -t;
            s = (i % 3 != 0);
            issue(a, b, s, acc);
            if (acc < 0) continue;
            wait_out(found, seen);
            checks++;
            if (!found) begin
                failures++;
                $display("FAIL random_%0d no out_valid", i);
                void'(sb_q.pop_front());
                continue;
            end
            e = sb_q.pop_front();
            checks++;
            if (quotient !== e.q || remainder !== e.r || div_by_zero !== e.dbz || seen - acc + 1 !== e.lat) begin
                failures++;
                $display("FAIL random_%0d a=%h b=%h s=%b got q=%h r=%h dbz=%b lat=%0d want q=%h r=%h dbz=%b lat=%0d",
                         i, a, b, s, quotient, remainder, div_by_zero, seen - acc + 1, e.q, e.r, e.dbz, e.lat);
            end
            release_out();
        end
    endtask

    // Continuous requester and consumer: second accept lands one cycle after the first output transfer.
    task automatic test_back_to_back();
        int n; exp_t e;
        acc_q.delete();
        xfer_q.delete();
        out_ready = 1'b1;
        @(negedge clk);
        dividend = 32'd1000; divisor = 32'd7; is_signed = 1'b0; in_valid = 1'b1;
        sb_q.push_back(model(32'd1000, 32'd7, 1'b0));
        for (int k = 0; k < 100 && acc_q.size() == 0; k++) @(negedge clk);
        dividend = 32'hFFFF_FF00; divisor = 32'd16; is_signed = 1'b1;
        sb_q.push_back(model(32'hFFFF_FF00, 32'd16, 1'b1));
        n = 0;
        for (int k = 0; k < 200 && n < 2; k++) begin
            @(negedge clk);
            if (acc_q.size() >= 2) in_valid = 1'b0;
            if (out_valid === 1'b1) begin
                e = sb_q.pop_front();
                checks++;
                if (quotient !== e.q || remainder !== e.r || div_by_zero !== e.dbz) begin
                    failures++;
                    $display("FAIL b2b_result_%0d got q=%h r=%h dbz=%b want q=%h r=%h dbz=%b",
                             n, quotient, remainder, div_by_zero, e.q, e.r, e.dbz);
                end
                n++;
            end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        checks++;
        if (n !== 2) begin
            failures++;
            $display("FAIL b2b_count got %0d results want 2", n);
            sb_q.delete();
        end
        checks++;
        if (acc_q.size() != 2 || xfer_q.size() != 2) begin
            failures++;
            $display("FAIL b2b_handshakes got accepts=%0d transfers=%0d want 2 2", acc_q.size(), xfer_q.size());
        end else if (acc_q[1] != xfer_q[0] + 1) begin
            failures++;
            $display("FAIL b2b_timing second accept at %0d want %0d", acc_q[1], xfer_q[0] + 1);
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        dividend  = '0;
        divisor   = '0;
        is_signed = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_unsigned();
        test_signed();
        test_div_by_zero();
        test_overflow_hold();
        test_reset_mid_busy();
        test_random();
        test_back_to_back();
        test_reset_in_done();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
